// File: rtl/bcci_cfg_pkg.sv
// bcci_cfg_pkg: bcci_ip CRF register map, sequencer states and error codes
package bcci_cfg_pkg;
  localparam logic [7:0] CTRL_OFS   = 8'h00;
  localparam logic [7:0] SRC_W_OFS  = 8'h04;
  localparam logic [7:0] SRC_H_OFS  = 8'h08;
  localparam logic [7:0] DST_W_OFS  = 8'h0C;
  localparam logic [7:0] DST_H_OFS  = 8'h10;
  localparam logic [7:0] STATUS_OFS = 8'h14;
  localparam int START_BIT = 0;
  localparam int DONE_BIT  = 0;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BRESP   = 2'd1;
  localparam logic [1:0] ERR_RD      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_WAIT_IRQ, S_RD_REQ, S_RD_RESP, S_DONE, S_ERR
  } state_t;
  // write program: 0..3 dimensions, 4 START, 5 STATUS clear
  function automatic logic [7:0] wr_ofs(input logic [2:0] idx);
    return idx == 3'd0 ? SRC_W_OFS : idx == 3'd1 ? SRC_H_OFS :
           idx == 3'd2 ? DST_W_OFS : idx == 3'd3 ? DST_H_OFS :
           idx == 3'd4 ? CTRL_OFS  : STATUS_OFS;
  endfunction
endpackage

// File: rtl/bcci_cfg_seq.sv
// bcci_cfg_seq: AXI4-Lite master that programs the bcci_ip CRF for one frame and waits for completion
module bcci_cfg_seq
  import bcci_cfg_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int SRC_IMG_WIDTH  = 960,
  parameter int SRC_IMG_HEIGHT = 540,
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o,
  output logic [15:0]                 frame_cnt_o,
  input  logic                        interrupt_updone,
  output logic                        m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  input  logic                        m_axi_awready,
  output logic                        m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_bready,
  output logic                        m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_arready,
  input  logic                        m_axi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  output logic                        m_axi_rready
);
  localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t                    r_state;
  logic [2:0]                r_idx;
  logic [TW-1:0]             r_tcnt;
  logic [15:0]               r_frame_cnt;
  logic                      r_busy, r_done, r_err;
  logic [1:0]                r_err_code;
  logic                      r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic                      w_aw_ok, w_w_ok, w_load, w_rd_ok;
  logic [2:0]                w_ld_idx;
  logic [AXI_DATA_WIDTH-1:0] w_ld_data;
  logic                      w_unused;
  // a channel is finished once its valid has dropped or it handshakes this cycle
  assign w_aw_ok  = !r_awvalid || m_axi_awready;
  assign w_w_ok   = !r_wvalid || m_axi_wready;
  assign w_rd_ok  = m_axi_rresp == 2'b00 && m_axi_rdata[DONE_BIT];
  assign w_load   = (r_state == S_IDLE && start_i) ||
                    (r_state == S_WR_RESP && m_axi_bvalid && m_axi_bresp == 2'b00 && r_idx < 3'd4) ||
                    (r_state == S_RD_RESP && m_axi_rvalid && w_rd_ok);
  assign w_ld_idx = r_state == S_IDLE ? 3'd0 : r_state == S_RD_RESP ? 3'd5 : r_idx + 3'd1;
  assign w_ld_data = w_ld_idx == 3'd0 ? AXI_DATA_WIDTH'(SRC_IMG_WIDTH) :
                     w_ld_idx == 3'd1 ? AXI_DATA_WIDTH'(SRC_IMG_HEIGHT) :
                     w_ld_idx == 3'd2 ? AXI_DATA_WIDTH'(DST_IMG_WIDTH) :
                     w_ld_idx == 3'd3 ? AXI_DATA_WIDTH'(DST_IMG_HEIGHT) :
                     w_ld_idx == 3'd4 ? AXI_DATA_WIDTH'(1) << START_BIT : AXI_DATA_WIDTH'(1) << DONE_BIT;
  assign w_unused = ^m_axi_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_tcnt      <= '0;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_state    <= S_WR_REQ;
          r_busy     <= 1'b1;
          r_err      <= 1'b0;
          r_err_code <= ERR_NONE;
        end
        S_WR_REQ: begin
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready) r_wvalid <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_state  <= S_WR_RESP;
            r_bready <= 1'b1;
          end
        end
        S_WR_RESP: if (m_axi_bvalid) begin
          r_bready <= 1'b0;
          if (m_axi_bresp != 2'b00) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_BRESP;
          end else if (r_idx < 3'd4) r_state <= S_WR_REQ;
          else if (r_idx == 3'd4) begin
            r_state <= S_WAIT_IRQ;
            r_tcnt  <= '0;
          end else begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        S_WAIT_IRQ: if (interrupt_updone) begin
          r_state   <= S_RD_REQ;
          r_arvalid <= 1'b1;
          r_araddr  <= AXI_ADDR_WIDTH'(STATUS_OFS);
        end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_state    <= S_ERR;
          r_err      <= 1'b1;
          r_err_code <= ERR_TIMEOUT;
        end else r_tcnt <= r_tcnt + 1'b1;
        S_RD_REQ: if (m_axi_arready) begin
          r_state   <= S_RD_RESP;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
        end
        S_RD_RESP: if (m_axi_rvalid) begin
          r_rready <= 1'b0;
          r_state  <= w_rd_ok ? S_WR_REQ : S_ERR;
          if (!w_rd_ok) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_RD;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_load) begin
        r_idx     <= w_ld_idx;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_awaddr  <= AXI_ADDR_WIDTH'(wr_ofs(w_ld_idx));
        r_wdata   <= w_ld_data;
      end
    end
  end
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign err_code_o    = r_err_code;
  assign frame_cnt_o   = r_frame_cnt;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = r_rready;
endmodule

// File: doc/bcci_cfg_seq.md
Name: bcci_cfg_seq

Overview:
- AXI4-Lite master sequencer that programs the bcci_ip control register file (CRF) for one frame.
- Sequence: writes source/destination dimensions, writes START, waits for interrupt_updone, reads STATUS, clears it.
- Sits between the system host/test controller and the bcci_ip s_axi_* slave port, so an upscale can run without a CPU.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI-Lite address width
- AXI_DATA_WIDTH, 32, AXI-Lite data width
- SRC_IMG_WIDTH, 960, value written to SRC_W
- SRC_IMG_HEIGHT, 540, value written to SRC_H
- DST_IMG_WIDTH, 3840, value written to DST_W
- DST_IMG_HEIGHT, 2160, value written to DST_H
- TIMEOUT_CYCLES, 2**24, maximum cycles waited for interrupt_updone

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  frame request; sampled only in IDLE
- busy_o  out  1  high from the cycle after start acceptance until DONE/ERR exit
- done_o  out  1  one-cycle pulse on successful frame
- err_o  out  1  sticky error; cleared on next accepted start
- err_code_o  out  2  0 none, 1 bresp!=OKAY, 2 rresp!=OKAY or STATUS.done=0, 3 timeout
- frame_cnt_o  out  16  successful frames, wraps 0xFFFF->0
- interrupt_updone  in  1  level from bcci_ip
- m_axi_awvalid/awaddr/awprot  out  1/AXI_ADDR_WIDTH/3
- m_axi_awready  in  1
- m_axi_wvalid/wdata/wstrb  out  1/AXI_DATA_WIDTH/AXI_DATA_WIDTH/8
- m_axi_wready  in  1
- m_axi_bvalid/bresp  in  1/2
- m_axi_bready  out  1
- m_axi_arvalid/araddr/arprot  out  1/AXI_ADDR_WIDTH/3
- m_axi_arready  in  1
- m_axi_rvalid/rdata/rresp  in  1/AXI_DATA_WIDTH/2
- m_axi_rready  out  1

Behaviour:
- Reset: all outputs 0; awprot/arprot=0; state IDLE; frame_cnt_o=0.
- wstrb is always all-ones.
- Register map (bcci_ip CRF): CTRL 0x00 (bit0 START), SRC_W 0x04, SRC_H 0x08, DST_W 0x0C, DST_H 0x10, STATUS 0x14 (bit0 DONE, write-1-to-clear).
- Write program index 0..5: SRC_W, SRC_H, DST_W, DST_H, CTRL=1, STATUS=1. Index 5 is the clear write, issued after the read.
- States: IDLE, WR_REQ, WR_RESP, WAIT_IRQ, RD_REQ, RD_RESP, DONE, ERR.
- IDLE:
  - start_i=1 -> WR_REQ, idx=0, err_o/err_code_o cleared.
  - A start_i pulse while not in IDLE is ignored. No queueing.
- WR_REQ:
  - Assert awvalid and wvalid together. Each drops independently on its own handshake (aw_done/w_done flags).
  - Both done -> WR_RESP. Same-cycle aw and w handshakes are legal.
  - awaddr/wdata stay stable while valid is high.
- WR_RESP:
  - bready=1.
  - On bvalid: bresp!=0 -> ERR (code 1).
  - Else if idx<4: idx++ -> WR_REQ.
  - Else if idx==4 -> WAIT_IRQ.
  - Else (idx==5) -> DONE.
- WAIT_IRQ:
  - Timeout counter starts at 0.
  - interrupt_updone=1 -> RD_REQ.
  - Counter reaches TIMEOUT_CYCLES-1 without irq -> ERR (code 3).
  - irq and timeout in the same cycle: irq wins.
- RD_REQ: arvalid=1, araddr=0x14; on arready -> RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: rresp!=0 or rdata[0]==0 -> ERR (code 2).
  - Else idx=5 -> WR_REQ.
- DONE: done_o=1 for one cycle, frame_cnt_o++ -> IDLE.
- ERR: err_o=1, err_code_o latched -> IDLE. No further bus traffic.
- busy_o=1 in every state except IDLE.
- Outstanding transactions: at most one; never issues AR while a write is pending.
- Async rst mid-transaction: all valids drop immediately. The bcci_ip bus is reset by the same rst.

Decomposition:
- Package bcci_cfg_pkg: register offset constants, state enum, err_code localparams, START/DONE bit positions.
- No sub-module needed.
- Optional sub-module bcci_axil_wr_chan (AW/W independent-handshake tracker), reusable by other masters.

Test Plan:
- Zero-wait slave, start_i pulse -> writes 0x04=960, 0x08=540, 0x0C=3840, 0x10=2160, 0x00=1 in order. Then irq after 100 cycles -> read 0x14 returns 1 -> write 0x14=1 -> done_o pulse, frame_cnt_o=1.
- Slave delays awready 3 cycles and wready 0 cycles on each write -> wvalid drops after 1 cycle, awvalid holds 3 cycles. Same data sequence; no duplicate writes.
- bresp=2'b10 on the SRC_H write -> err_o=1, err_code_o=1, no further AW issued, busy_o=0 next cycle.
- TIMEOUT_CYCLES=16, irq never asserted -> err_o=1, err_code_o=3 exactly 16 cycles after CTRL bresp.
- STATUS read returns 0 -> err_code_o=2, no clear write.
- rst asserted during WAIT_IRQ then released, start_i again -> full sequence, frame_cnt_o=1.
- frame_cnt_o preloaded via force to 0xFFFF, one frame run -> frame_cnt_o=0.
